// File: rtl/line_prefetch_arbiter_pkg.sv
// Shared defaults and FSM encoding for the line prefetch arbiter and its wait timer.
package line_prefetch_arbiter_pkg;

    localparam int DEF_ROW_W   = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_BANK_W  = 2;
    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_DONE,
        S_CAPTURE
    } state_t;

endpackage

// File: rtl/line_prefetch_arbiter_timer.sv
// Saturating wait-cycle counter; o_expired flags that the wait budget is used up.
module line_prefetch_arbiter_timer
    import line_prefetch_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT - 1
) (
    input  logic CLK,
    input  logic Reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/line_prefetch_arbiter.sv
// Single-FSM requester for memoryController: per-line row prefetch into a ping-pong
// shadow register plus a single-entry write port, with Reset/Done handshake and timeout.
module line_prefetch_arbiter
    import line_prefetch_arbiter_pkg::*;
#(
    parameter int ROW_W   = DEF_ROW_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BANK_W  = DEF_BANK_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              LineStart,
    input  logic [ROW_W-1:0]  LineRow,
    input  logic [BANK_W-1:0] DisplayBank,
    output logic [DATA_W-1:0] LineData,
    output logic              LineValid,
    input  logic              WrReq,
    input  logic [ROW_W-1:0]  WrRow,
    input  logic [BANK_W-1:0] WrBank,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrAck,
    output logic [ROW_W-1:0]  MemRow,
    output logic [BANK_W-1:0] MemBank,
    output logic [DATA_W-1:0] MemIn,
    output logic              MemWrite,
    output logic              MemReset,
    input  logic [DATA_W-1:0] MemOut,
    input  logic              MemDone,
    output logic              Underrun,
    output logic              Timeout,
    output logic              Busy
);

    state_t              r_state;
    state_t              w_next;
    logic                r_pend_rd;
    logic [ROW_W-1:0]    r_pend_row;
    logic [BANK_W-1:0]   r_pend_bank;
    logic                r_op_write;
    logic [ROW_W-1:0]    r_mem_row;
    logic [BANK_W-1:0]   r_mem_bank;
    logic [DATA_W-1:0]   r_mem_in;
    logic [DATA_W-1:0]   r_shadow;
    logic                r_shadow_valid;
    logic [DATA_W-1:0]   r_line_data;
    logic                r_line_valid;
    logic                r_underrun;
    logic                r_timeout;
    logic                w_issue_rd;
    logic                w_issue_wr;
    logic                w_abort;
    logic                w_expired;
    logic                w_cap_rd;
    logic                w_rd_inflight;

    line_prefetch_arbiter_timer #(
        .LIMIT (TIMEOUT - 1)
    ) u_timer (
        .CLK       (CLK),
        .Reset     (Reset),
        .i_clr     (r_state == S_ISSUE),
        .i_en      ((r_state == S_WAIT_LOW) || (r_state == S_WAIT_DONE)),
        .o_expired (w_expired)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_issue_rd = 1'b0;
        w_issue_wr = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            // A LineStart arriving in IDLE counts as a pending read, so it beats WrReq.
            S_IDLE: begin
                if (r_pend_rd || LineStart) begin
                    w_issue_rd = 1'b1;
                    w_next     = S_ISSUE;
                end else if (WrReq) begin
                    w_issue_wr = 1'b1;
                    w_next     = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT_LOW;
            // Done must be seen low before it may complete the op; a stale high is ignored.
            S_WAIT_LOW: begin
                if (!MemDone) begin
                    w_next = S_WAIT_DONE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (MemDone) begin
                    w_next = S_CAPTURE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_cap_rd      = (r_state == S_CAPTURE) && !r_op_write;
    assign w_rd_inflight = (r_state != S_IDLE) && !r_op_write;

    // NOTE: the shadow and line registers are plain flops, so they reset with everything else.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_pend_rd      <= 1'b0;
            r_pend_row     <= '0;
            r_pend_bank    <= '0;
            r_op_write     <= 1'b0;
            r_mem_row      <= '0;
            r_mem_bank     <= '0;
            r_mem_in       <= '0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_line_data    <= '0;
            r_line_valid   <= 1'b0;
            r_underrun     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_issue_rd) begin
                r_op_write <= 1'b0;
                r_mem_row  <= r_pend_rd ? r_pend_row  : LineRow;
                r_mem_bank <= r_pend_rd ? r_pend_bank : DisplayBank;
            end else if (w_issue_wr) begin
                r_op_write <= 1'b1;
                r_mem_row  <= WrRow;
                r_mem_bank <= WrBank;
                r_mem_in   <= WrData;
            end

            // A LineStart consumed directly by an IDLE issue does not leave a pending read.
            if (LineStart && !(w_issue_rd && !r_pend_rd)) begin
                r_pend_rd   <= 1'b1;
                r_pend_row  <= LineRow;
                r_pend_bank <= DisplayBank;
            end else if (w_issue_rd) begin
                r_pend_rd <= 1'b0;
            end

            if (w_abort) begin
                r_timeout <= 1'b1;
            end

            if (LineStart) begin
                if (w_cap_rd) begin
                    r_line_data    <= MemOut;
                    r_line_valid   <= 1'b1;
                    r_shadow_valid <= 1'b0;
                end else if (r_shadow_valid) begin
                    r_line_data    <= r_shadow;
                    r_line_valid   <= 1'b1;
                    r_shadow_valid <= 1'b0;
                    if (w_rd_inflight) begin
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_line_valid <= 1'b0;
                    r_underrun   <= 1'b1;
                end
            end else if (w_cap_rd) begin
                r_shadow       <= MemOut;
                r_shadow_valid <= 1'b1;
            end
        end
    end

    assign LineData  = r_line_data;
    assign LineValid = r_line_valid;
    assign WrAck     = (r_state == S_CAPTURE) && r_op_write;
    assign MemRow    = r_mem_row;
    assign MemBank   = r_mem_bank;
    assign MemIn     = r_mem_in;
    assign MemWrite  = r_op_write;
    assign MemReset  = (r_state == S_ISSUE);
    assign Underrun  = r_underrun;
    assign Timeout   = r_timeout;
    assign Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_line_prefetch_arbiter.sv
// Directed bench for line_prefetch_arbiter with a behavioural memoryController model.
module tb_line_prefetch_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        LineStart;
    logic [3:0]  LineRow;
    logic [1:0]  DisplayBank;
    logic [15:0] LineData;
    logic        LineValid;
    logic        WrReq;
    logic [3:0]  WrRow;
    logic [1:0]  WrBank;
    logic [15:0] WrData;
    logic        WrAck;
    logic [3:0]  MemRow;
    logic [1:0]  MemBank;
    logic [15:0] MemIn;
    logic        MemWrite;
    logic        MemReset;
    logic [15:0] MemOut;
    logic        MemDone;
    logic        Underrun;
    logic        Timeout;
    logic        Busy;

    int passed = 0;
    int total  = 0;

    line_prefetch_arbiter dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .LineStart   (LineStart),
        .LineRow     (LineRow),
        .DisplayBank (DisplayBank),
        .LineData    (LineData),
        .LineValid   (LineValid),
        .WrReq       (WrReq),
        .WrRow       (WrRow),
        .WrBank      (WrBank),
        .WrData      (WrData),
        .WrAck       (WrAck),
        .MemRow      (MemRow),
        .MemBank     (MemBank),
        .MemIn       (MemIn),
        .MemWrite    (MemWrite),
        .MemReset    (MemReset),
        .MemOut      (MemOut),
        .MemDone     (MemDone),
        .Underrun    (Underrun),
        .Timeout     (Timeout),
        .Busy        (Busy)
    );

    always #5 CLK = ~CLK;

    // Controller model knobs: Done falls m_drop edges and rises m_lat edges after the start strobe.
    int   m_drop       = 0;
    int   m_lat        = 10;
    bit   m_never      = 1'b0;
    bit   m_ignore_rst = 1'b0;

    logic [15:0] mem [4][16];
    int          m_cnt;
    bit          m_busy;
    bit          m_wr;
    logic [3:0]  m_row;
    logic [1:0]  m_bank;
    logic [15:0] m_din;

    function automatic logic [15:0] init_word(int b, int r);
        if (b == 0 && r == 3) return 16'hA5A5;
        if (b == 0 && r == 7) return 16'h1234;
        if (b == 1 && r == 2) return 16'hBEEF;
        if (b == 0 && r == 4) return 16'h4444;
        return 16'h5000 | 16'(b * 16 + r);
    endfunction

    always @(posedge CLK) begin
        if (Reset && !m_ignore_rst) begin
            MemDone <= 1'b0;
            MemOut  <= 16'h0000;
            m_busy  = 1'b0;
            m_cnt   = 0;
            for (int b = 0; b < 4; b++)
                for (int r = 0; r < 16; r++)
                    mem[b][r] = init_word(b, r);
        end else if (MemReset === 1'b1) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_wr   = MemWrite;
            m_row  = MemRow;
            m_bank = MemBank;
            m_din  = MemIn;
            if (m_drop == 0) MemDone <= 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == m_drop) MemDone <= 1'b0;
            if (m_cnt == m_lat && !m_never) begin
                MemDone <= 1'b1;
                if (m_wr) mem[m_bank][m_row] = m_din;
                else      MemOut <= mem[m_bank][m_row];
                m_busy = 1'b0;
            end
        end
    end

    // Start-strobe and WrAck monitor, logging each issued op.
    int         rst_pulses = 0;
    int         ack_pulses = 0;
    logic       op_wr  [32];
    logic [3:0] op_row [32];

    always @(negedge CLK) begin
        if (MemReset === 1'b1) begin
            op_wr[rst_pulses % 32]  = MemWrite;
            op_row[rst_pulses % 32] = MemRow;
            rst_pulses++;
        end
        if (WrAck === 1'b1) ack_pulses++;
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        LineStart = 1'b0;
        WrReq     = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic line_start(input logic [3:0] row, input logic [1:0] bank);
        LineStart   = 1'b1;
        LineRow     = row;
        DisplayBank = bank;
        step();
        LineStart = 1'b0;
    endtask

    // Run until the arbiter has been idle with no write request for two cycles.
    task automatic settle(input int limit);
        int idle_run;
        int cycles;
        idle_run = 0;
        cycles   = 0;
        while (idle_run < 2 && cycles < limit) begin
            if (WrAck === 1'b1) WrReq = 1'b0;
            if (Busy === 1'b0 && WrReq === 1'b0) idle_run++;
            else idle_run = 0;
            step();
            cycles++;
        end
        total++;
        if (idle_run < 2) $display("FAIL settle_bound: still busy after %0d cycles", cycles);
        else passed++;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        LineStart   = 1'b0;
        LineRow     = 4'd0;
        DisplayBank = 2'd0;
        WrReq       = 1'b0;
        WrRow       = 4'd0;
        WrBank      = 2'd0;
        WrData      = 16'h0000;
        step();
        total++;
        if (|{LineData, LineValid, WrAck, MemRow, MemBank, MemIn, MemWrite, MemReset,
              Underrun, Timeout, Busy} !== 1'b0)
            $display("FAIL reset_outputs: some output nonzero, Busy=%b LineValid=%b MemReset=%b",
                     Busy, LineValid, MemReset);
        else passed++;
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_prefetch();
        int base;
        int n;
        m_drop = 0; m_lat = 10; m_never = 1'b0;
        do_reset();
        base = rst_pulses;
        line_start(4'd3, 2'd0);
        total++;
        if (MemReset !== 1'b1 || MemRow !== 4'd3 || MemBank !== 2'd0 || MemWrite !== 1'b0)
            $display("FAIL pf_issue: MemReset=%b MemRow=%0d MemBank=%0d MemWrite=%b want 1/3/0/0",
                     MemReset, MemRow, MemBank, MemWrite);
        else passed++;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        total++;
        if (n !== 13) $display("FAIL pf_latency: busy %0d cycles want 13", n);
        else passed++;
        total++;
        if (rst_pulses - base !== 1) $display("FAIL pf_strobes: %0d start strobes want 1", rst_pulses - base);
        else passed++;
        line_start(4'd9, 2'd0);
        total++;
        if (LineData !== 16'hA5A5 || LineValid !== 1'b1)
            $display("FAIL pf_swap: LineData=%h LineValid=%b want a5a5/1", LineData, LineValid);
        else passed++;
        settle(100);
    endtask

    task automatic test_bypass();
        m_drop = 0; m_lat = 10; m_never = 1'b0;
        do_reset();
        line_start(4'd3, 2'd0);
        for (int i = 0; i < 12; i++) step();
        line_start(4'd9, 2'd0);
        total++;
        if (LineData !== 16'hA5A5 || LineValid !== 1'b1)
            $display("FAIL bypass_data: LineData=%h LineValid=%b want a5a5/1", LineData, LineValid);
        else passed++;
        settle(100);
        line_start(4'd0, 2'd0);
        total++;
        if (LineData !== 16'h5009 || LineValid !== 1'b1)
            $display("FAIL bypass_next: LineData=%h LineValid=%b want 5009/1", LineData, LineValid);
        else passed++;
        settle(100);
    endtask

    task automatic test_write();
        int abase;
        m_drop = 0; m_lat = 10; m_never = 1'b0;
        do_reset();
        abase  = ack_pulses;
        WrRow  = 4'd5;
        WrBank = 2'd0;
        WrData = 16'h0042;
        WrReq  = 1'b1;
        step();
        total++;
        if (MemReset !== 1'b1 || MemWrite !== 1'b1 || MemIn !== 16'h0042 || MemRow !== 4'd5)
            $display("FAIL wr_issue: MemReset=%b MemWrite=%b MemIn=%h MemRow=%0d want 1/1/0042/5",
                     MemReset, MemWrite, MemIn, MemRow);
        else passed++;
        settle(100);
        total++;
        if (ack_pulses - abase !== 1) $display("FAIL wr_ack: %0d WrAck pulses want 1", ack_pulses - abase);
        else passed++;
        line_start(4'd5, 2'd0);
        settle(100);
        line_start(4'd0, 2'd0);
        total++;
        if (LineData !== 16'h0042 || LineValid !== 1'b1)
            $display("FAIL wr_readback: LineData=%h LineValid=%b want 0042/1", LineData, LineValid);
        else passed++;
        settle(100);
    endtask

    task automatic test_arbitration();
        int base;
        int abase;
        m_drop = 0; m_lat = 10; m_never = 1'b0;
        do_reset();
        base        = rst_pulses;
        abase       = ack_pulses;
        LineStart   = 1'b1;
        LineRow     = 4'd3;
        DisplayBank = 2'd0;
        WrRow       = 4'd6;
        WrBank      = 2'd0;
        WrData      = 16'h7777;
        WrReq       = 1'b1;
        step();
        LineStart = 1'b0;
        total++;
        if (MemWrite !== 1'b0 || MemRow !== 4'd3)
            $display("FAIL arb_first: MemWrite=%b MemRow=%0d want 0/3", MemWrite, MemRow);
        else passed++;
        settle(200);
        total++;
        if (rst_pulses - base !== 2 || op_wr[base % 32] !== 1'b0 || op_row[base % 32] !== 4'd3 ||
            op_wr[(base + 1) % 32] !== 1'b1 || op_row[(base + 1) % 32] !== 4'd6)
            $display("FAIL arb_order: ops=%0d first=%b/%0d second=%b/%0d want 2 0/3 1/6",
                     rst_pulses - base, op_wr[base % 32], op_row[base % 32],
                     op_wr[(base + 1) % 32], op_row[(base + 1) % 32]);
        else passed++;
        total++;
        if (ack_pulses - abase !== 1) $display("FAIL arb_ack: %0d WrAck pulses want 1", ack_pulses - abase);
        else passed++;
    endtask

    task automatic test_stale_done();
        int k;
        m_drop = 3; m_lat = 6; m_never = 1'b0;
        do_reset();
        line_start(4'd7, 2'd0);
        step();
        step();
        line_start(4'd2, 2'd1);
        total++;
        if (Underrun !== 1'b1 || LineValid !== 1'b0)
            $display("FAIL stale_underrun: Underrun=%b LineValid=%b want 1/0", Underrun, LineValid);
        else passed++;
        k = 0;
        while (Busy === 1'b1 && k < 50) begin k++; step(); end
        k = 0;
        while (MemReset !== 1'b1 && k < 5) begin k++; step(); end
        total++;
        if (MemReset !== 1'b1 || MemRow !== 4'd2 || MemBank !== 2'd1 || MemWrite !== 1'b0)
            $display("FAIL stale_second_issue: MemReset=%b MemRow=%0d MemBank=%0d want 1/2/1",
                     MemReset, MemRow, MemBank);
        else passed++;
        line_start(4'd4, 2'd0);
        total++;
        if (LineData !== 16'h1234 || LineValid !== 1'b1)
            $display("FAIL stale_first_data: LineData=%h LineValid=%b want 1234/1", LineData, LineValid);
        else passed++;
        k = 0;
        while (Busy === 1'b1 && k < 50) begin k++; step(); end
        k = 0;
        while (MemReset !== 1'b1 && k < 5) begin k++; step(); end
        total++;
        if (MemReset !== 1'b1 || MemRow !== 4'd4 || MemBank !== 2'd0)
            $display("FAIL stale_third_issue: MemReset=%b MemRow=%0d MemBank=%0d want 1/4/0",
                     MemReset, MemRow, MemBank);
        else passed++;
        line_start(4'd0, 2'd0);
        total++;
        if (LineData !== 16'hBEEF || LineValid !== 1'b1)
            $display("FAIL stale_second_data: LineData=%h LineValid=%b want beef/1", LineData, LineValid);
        else passed++;
        settle(200);
        line_start(4'd0, 2'd0);
        total++;
        if (LineData !== 16'h5000 || LineValid !== 1'b1)
            $display("FAIL stale_last_data: LineData=%h LineValid=%b want 5000/1", LineData, LineValid);
        else passed++;
        settle(200);
    endtask

    task automatic test_timeout();
        int base;
        int n;
        m_drop = 0; m_lat = 10; m_never = 1'b1;
        do_reset();
        base = rst_pulses;
        line_start(4'd1, 2'd0);
        total++;
        if (Timeout !== 1'b0) $display("FAIL to_early: Timeout=%b want 0", Timeout);
        else passed++;
        n = 0;
        while (Busy === 1'b1 && n < 400) begin
            n++;
            step();
        end
        total++;
        if (n !== 256) $display("FAIL to_latency: busy %0d cycles want 256", n);
        else passed++;
        total++;
        if (Timeout !== 1'b1 || Busy !== 1'b0)
            $display("FAIL to_flag: Timeout=%b Busy=%b want 1/0", Timeout, Busy);
        else passed++;
        for (int i = 0; i < 5; i++) step();
        total++;
        if (Busy !== 1'b0 || rst_pulses - base !== 1)
            $display("FAIL to_no_retry: Busy=%b strobes=%0d want 0/1", Busy, rst_pulses - base);
        else passed++;
        m_never = 1'b0;
    endtask

    task automatic test_reset_midop();
        int abase;
        int sbase;
        m_drop = 0; m_lat = 10; m_never = 1'b0; m_ignore_rst = 1'b0;
        do_reset();
        m_ignore_rst = 1'b1;
        WrRow  = 4'd8;
        WrBank = 2'd1;
        WrData = 16'h9999;
        WrReq  = 1'b1;
        step();
        step();
        step();
        total++;
        if (Busy !== 1'b1 || MemWrite !== 1'b1)
            $display("FAIL rm_inflight: Busy=%b MemWrite=%b want 1/1", Busy, MemWrite);
        else passed++;
        abase = ack_pulses;
        Reset = 1'b1;
        #1;
        total++;
        if (|{LineData, LineValid, WrAck, MemRow, MemBank, MemIn, MemWrite, MemReset,
              Underrun, Timeout, Busy} !== 1'b0)
            $display("FAIL rm_outputs: some output nonzero, Busy=%b MemWrite=%b MemIn=%h",
                     Busy, MemWrite, MemIn);
        else passed++;
        WrReq = 1'b0;
        step();
        Reset = 1'b0;
        sbase = rst_pulses;
        for (int i = 0; i < 15; i++) step();
        total++;
        if (ack_pulses - abase !== 0 || LineValid !== 1'b0 || Busy !== 1'b0 || rst_pulses - sbase !== 0)
            $display("FAIL rm_late_done: acks=%0d LineValid=%b Busy=%b strobes=%0d want 0/0/0/0",
                     ack_pulses - abase, LineValid, Busy, rst_pulses - sbase);
        else passed++;
        m_ignore_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_bypass();
        test_write();
        test_arbitration();
        test_stale_done();
        test_timeout();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
